// File: rtl/norm_pkg.sv
// Shared widths and the per-stage payload carried down the normalization pipeline.
// Flow control lives in norm_shifter; this package holds types only.
package norm_pkg;

   localparam int NORM_N     = 32;
   localparam int INDEX_W    = $clog2(NORM_N);
   localparam int NORM_EXP_W = 8;

   typedef struct packed {
      logic                  valid;
      logic [NORM_N-1:0]     data;
      logic [INDEX_W-1:0]    shamt;
      logic [NORM_EXP_W-1:0] exp;
      logic                  zero;
      logic                  uflow;
   } stage_t;

endpackage

// File: rtl/find_first_one.sv
// Leading-one index: position of the highest set bit of data, 0 when data is zero.
// Purely combinational, no flow control.
module find_first_one #(
   parameter int N = 32
) (
   input  logic [N-1:0]         data,
   output logic [$clog2(N)-1:0] index
);

   always_comb begin
      index = '0;
      for (int i = 0; i < N; i++) begin
         if (data[i]) index = i[$clog2(N)-1:0];
      end
   end

endmodule

// File: rtl/norm_stage.sv
// One pipeline stage: shift left by SHIFT when shamt bit BIT is set; one cycle latency.
// Holds its register whenever advance is low, so the whole pipe stalls as one.
module norm_stage
   import norm_pkg::*;
#(
   parameter int SHIFT = 1,
   parameter int BIT   = 0
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   advance,
   input  stage_t stage_in,
   output stage_t stage_out
);

   stage_t stage_d, stage_q;

   always_comb begin
      stage_d = stage_q;
      if (advance) begin
         stage_d = stage_in;
         if (stage_in.shamt[BIT]) stage_d.data = stage_in.data << SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stage_q <= '0;
      else       stage_q <= stage_d;
   end

   assign stage_out = stage_q;

endmodule

// File: rtl/norm_shifter.sv
// Mantissa normalizer: $clog2(N) registered log-shift stages, result $clog2(N) cycles after acceptance.
// Valid/ready with a single global advance; NORM_SELFCHECK_EN adds a sticky leading-one index check on err.
module norm_shifter
   import norm_pkg::*;
#(
   parameter int N     = NORM_N,
   parameter int EXP_W = NORM_EXP_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_index,
   input  logic [EXP_W-1:0]     in_exp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_mant,
   output logic [EXP_W-1:0]     out_exp,
   output logic                 out_zero,
   output logic                 out_uflow,
   output logic                 err
);

   localparam int             LOG     = $clog2(N);
   localparam logic [LOG-1:0] MAX_IDX = LOG'(N - 1);

   logic                 advance;
   logic                 in_fire;
   logic                 in_zero;
   logic [LOG-1:0]       shamt;
   logic [EXP_W+LOG-1:0] exp_ext, sh_ext, exp_diff;
   stage_t               pipe [0:LOG];
   stage_t               out_s;
   logic                 unused_shamt;

   assign advance  = !out_s.valid || out_ready;
   assign in_ready = advance;

   // Exponent adjustment is resolved at entry so the stages only move data.
   always_comb begin
      in_zero  = (in_data == '0);
      in_fire  = in_valid && advance;
      shamt    = in_zero ? '0 : MAX_IDX - in_index;
      exp_ext  = {{LOG{1'b0}}, in_exp};
      sh_ext   = {{EXP_W{1'b0}}, shamt};
      exp_diff = exp_ext - sh_ext;

      pipe[0]       = '0;
      pipe[0].valid = in_fire;
      pipe[0].data  = in_data;
      pipe[0].shamt = shamt;
      pipe[0].zero  = in_zero;
      if (!in_zero) begin
         if (exp_ext >= sh_ext) pipe[0].exp   = exp_diff[EXP_W-1:0];
         else                   pipe[0].uflow = 1'b1;
      end
   end

   for (genvar k = 0; k < LOG; k++) begin : g_stage
      norm_stage #(
         .SHIFT (N >> (k + 1)),
         .BIT   (LOG - 1 - k)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .advance   (advance),
         .stage_in  (pipe[k]),
         .stage_out (pipe[k+1])
      );
   end

   assign out_s        = pipe[LOG];
   assign out_valid    = out_s.valid;
   assign out_mant     = out_s.data;
   assign out_exp      = out_s.exp;
   assign out_zero     = out_s.zero;
   assign out_uflow    = out_s.uflow;
   assign unused_shamt = ^out_s.shamt;

`ifdef NORM_SELFCHECK_EN
   logic [LOG-1:0] ffo_index;
   logic           err_d, err_q;

   find_first_one #(
      .N (N)
   ) u_ffo (
      .data  (in_data),
      .index (ffo_index)
   );

   always_comb begin
      err_d = err_q | (in_fire && !in_zero && (ffo_index != in_index));
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_norm_shifter.sv
// Directed bench for norm_shifter (N=32, EXP_W=8): latency, exponent/underflow/zero cases,
// stall hold, ordering, reset flush and the optional index self-check.
module tb_norm_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_index;
   logic [7:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_mant;
   logic [7:0]  out_exp;
   logic        out_zero;
   logic        out_uflow;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   norm_shifter #(
      .N     (32),
      .EXP_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_index  (in_index),
      .in_exp    (in_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_zero  (out_zero),
      .out_uflow (out_uflow),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] idx,
                          input logic [7:0] e, input logic [31:0] xm, input logic [7:0] xe,
                          input logic xz, input logic xu);
      int lat;
      in_valid = 1'b1;
      in_data  = d;
      in_index = idx;
      in_exp   = e;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(5));
      chk({tag, "_mant"}, 64'(out_mant), 64'(xm));
      chk({tag, "_exp"}, 64'(out_exp), 64'(xe));
      chk({tag, "_zero"}, 64'(out_zero), 64'(xz));
      chk({tag, "_uflow"}, 64'(out_uflow), 64'(xu));
      tick();
      chk({tag, "_bubble"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      int          sent;
      int          recv;
      int          cyc;
      int          stalls;
      int          extra;
      logic [31:0] held_mant;
      logic [7:0]  held_exp;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_index  = '0;
      in_exp    = '0;
      out_ready = 1'b1;
      held_mant = '0;
      held_exp  = '0;

      @(posedge clk);
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_mant", 64'(out_mant), 64'(0));
      chk("rst_out_exp", 64'(out_exp), 64'(0));
      chk("rst_out_zero", 64'(out_zero), 64'(0));
      chk("rst_out_uflow", 64'(out_uflow), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      reset = 1'b0;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'(1));

      run_one("lsb", 32'h0000_0001, 5'd0, 8'd100, 32'h8000_0000, 8'd69, 1'b0, 1'b0);
      run_one("uflow", 32'h0000_F000, 5'd15, 8'd10, 32'hF000_0000, 8'd0, 1'b0, 1'b1);
      run_one("zero", 32'h0000_0000, 5'd7, 8'd50, 32'h0000_0000, 8'd0, 1'b1, 1'b0);
      run_one("noshift", 32'h8000_0001, 5'd31, 8'd7, 32'h8000_0001, 8'd7, 1'b0, 1'b0);
      run_one("exp_eq", 32'h0001_0000, 5'd16, 8'd15, 32'h8000_0000, 8'd0, 1'b0, 1'b0);
      run_one("exp_max", 32'h0000_0003, 5'd1, 8'd255, 32'hC000_0000, 8'd225, 1'b0, 1'b0);

      // Beat i = (8+i)<<i normalizes to (8+i)<<28 with exponent 30-(28-i) = 2+i.
      sent   = 0;
      recv   = 0;
      cyc    = 0;
      stalls = 0;
      while (recv < 8 && cyc < 60) begin
         out_ready = !(cyc >= 6 && cyc <= 8);
         in_valid  = (sent < 8);
         in_data   = 32'(8 + sent) << sent;
         in_index  = 5'(3 + sent);
         in_exp    = 8'd30;
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            if (stalls == 0) begin
               held_mant = out_mant;
               held_exp  = out_exp;
            end else begin
               chk("stall_hold_mant", 64'(out_mant), 64'(held_mant));
               chk("stall_hold_exp", 64'(out_exp), 64'(held_exp));
            end
            stalls++;
         end
         if (out_valid && out_ready) begin
            chk("stream_mant", 64'(out_mant), 64'(32'(8 + recv) << 28));
            chk("stream_exp", 64'(out_exp), 64'(2 + recv));
            chk("stream_uflow", 64'(out_uflow), 64'(0));
            recv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_recv", 64'(recv), 64'(8));
      chk("stream_sent", 64'(sent), 64'(8));
      chk("stream_stalls", 64'(stalls), 64'(3));
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) extra++;
         tick();
      end
      chk("stream_no_dup", 64'(extra), 64'(0));

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h0000_0001 << i;
         in_index = 5'(i);
         in_exp   = 8'd40;
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      reset = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) extra++;
      end
      chk("flush_no_stale", 64'(extra), 64'(0));

`ifdef NORM_SELFCHECK_EN
      chk("selfchk_err_before", 64'(err), 64'(0));
      in_valid = 1'b1;
      in_data  = 32'h0000_0100;
      in_index = 5'd9;
      in_exp   = 8'd20;
      tick();
      in_valid = 1'b0;
      chk("selfchk_err_set", 64'(err), 64'(1));
      for (int i = 0; i < 4; i++) tick();
      chk("selfchk_err_sticky", 64'(err), 64'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("selfchk_err_cleared", 64'(err), 64'(0));
`else
      in_valid = 1'b1;
      in_data  = 32'h0000_0100;
      in_index = 5'd9;
      in_exp   = 8'd20;
      tick();
      in_valid = 1'b0;
      tick();
      chk("err_tied_low", 64'(err), 64'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/norm_shifter.md
NORM_SHIFTER -- requirements
Module: norm_shifter

Interface
REQ-001 SHALL have parameter N, default 32, meaning data width in bits (power of two, 8..64).
REQ-002 SHALL have parameter EXP_W, default 8, meaning unsigned exponent width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  N  value to normalize.
REQ-008 SHALL have port in_index  input  $clog2(N)  leading-one index of in_data (FindFirstOne output).
REQ-009 SHALL have port in_exp  input  EXP_W  exponent associated with in_data.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1, meaning output beat transfers when both high.
REQ-011 SHALL have port out_mant  output  N  normalized value, leading one at bit N-1.
REQ-012 SHALL have port out_exp  output  EXP_W  adjusted exponent.
REQ-013 SHALL have ports out_zero output 1 (input was zero) and out_uflow output 1 (exponent underflow).
REQ-014 SHALL have port err  output  1  sticky index-mismatch flag (see Configuration).

Function
REQ-015 SHALL compute shift amount shamt = N-1-in_index, latched at acceptance.
REQ-016 SHALL implement $clog2(N) pipeline stages; stage k shifts left by N/2^(k+1) when the corresponding shamt bit is set (32: 16, 8, 4, 2, 1).
REQ-017 SHALL present the result of an accepted beat on out_valid exactly $clog2(N) cycles after acceptance (5 for N=32) when out_ready is held high.
REQ-018 SHALL accept one beat per cycle with out_ready held high (full throughput).
REQ-019 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready = advance; no stage changes when advance is low.
REQ-020 SHALL hold out_mant, out_exp, out_zero, out_uflow stable while out_valid && !out_ready.
REQ-021 SHALL propagate a per-stage valid bit; bubbles (cycles with no accepted beat) SHALL appear as out_valid low in order.
REQ-022 SHALL, when in_exp >= shamt, output out_exp = in_exp - shamt and out_uflow = 0.
REQ-023 SHALL, when in_exp < shamt, output out_exp = 0, out_uflow = 1, out_mant still fully normalized.
REQ-024 SHALL, when in_data == 0, output out_zero = 1, out_mant = 0, out_exp = 0, out_uflow = 0, ignoring in_index.
REQ-025 SHALL pass in_data unshifted when in_index = N-1 (shamt 0), out_exp = in_exp.
REQ-026 SHALL treat a beat offered while in_ready is low as not accepted; the source holds it.

Reset
REQ-027 SHALL, with reset high at a clock edge, clear all stage valid bits, out_valid = 0, out_mant = 0, out_exp = 0, out_zero = 0, out_uflow = 0, err = 0.
REQ-028 SHALL drop in-flight beats on reset mid-operation; in_ready = 1 on the first cycle after reset deassertion.

Configuration
REQ-029 SHALL, with macro NORM_SELFCHECK_EN defined, compute the leading-one index of in_data at acceptance, and set err (sticky until reset) the cycle after a non-zero beat is accepted whose in_index differs.
REQ-030 SHALL, without NORM_SELFCHECK_EN, tie err to 0 and contain no checking logic.

Structure
REQ-031 SHALL take N defaults, INDEX_W, EXP_W and the stage payload struct (valid, data, shamt, exp, zero, uflow) from shared package norm_pkg.
REQ-032 SHALL build the pipeline from one sub-module norm_stage, parameterized by shift distance and shamt bit position, instantiated $clog2(N) times.
REQ-033 SHALL reuse the existing FindFirstOne module for the self-check under NORM_SELFCHECK_EN.

Verification
REQ-034 SHALL test: in_data=32'h0000_0001, in_index=0, in_exp=100 -> 5 cycles later out_mant=32'h8000_0000, out_exp=69, out_uflow=0.
REQ-035 SHALL test: in_data=32'h0000_F000, in_index=15, in_exp=10 -> out_mant=32'hF000_0000, out_exp=0, out_uflow=1.
REQ-036 SHALL test: in_data=0, in_index=7, in_exp=50 -> out_zero=1, out_mant=0, out_exp=0.
REQ-037 SHALL test: 8 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low during stall, outputs held, all 8 results in order, none lost or duplicated.
REQ-038 SHALL test: reset asserted with 3 beats in flight -> out_valid=0 next cycle, no stale beat emerges afterward.
REQ-039 SHALL test with NORM_SELFCHECK_EN: in_data=32'h0000_0100, in_index=9 -> err=1 one cycle after acceptance, remains 1 until reset.
